jury_vote_tally: RTL and testbench

//  Downstream of the jury-input encoder: consumes its 2-bit code {S1,S0} and tallies one vote per juror press

---
 rtl/jury_vote_tally.sv | 95 +++++++++
 tb/tb_jury_vote_tally.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/jury_vote_tally.sv
// Jury vote tally: counts edge-qualified yes/no codes from the jury encoder over a
// start-opened window, closes on N_JURY votes or timeout, and then publishes a held verdict.
module jury_vote_tally #(
    parameter int N_JURY  = 3,
    parameter int CNT_W   = 2,
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             S1,
    input  logic             S0,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] yes_cnt,
    output logic [CNT_W-1:0] no_cnt
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DECIDE  = 2'd2;

    localparam logic [CNT_W:0]   N_LAST   = (CNT_W+1)'(N_JURY);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_PASS = 2'b01;
    localparam logic [1:0] RES_FAIL = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    logic [1:0]       state;
    logic [1:0]       prev_code;
    logic [TMR_W-1:0] timer;
    logic [1:0]       code;
    logic             vote_yes;
    logic             vote_no;
    logic [CNT_W:0]   total_next;
    logic [CNT_W:0]   yes_wide;
    logic [CNT_W:0]   no_wide;
    logic             close_win;

    assign code     = {S1, S0};
    assign busy     = (state != ST_IDLE);
    assign yes_wide = {1'b0, yes_cnt};
    assign no_wide  = {1'b0, no_cnt};

    // A vote counts only on a transition out of the released (00) code.
    assign vote_yes = (prev_code == 2'b00) && (code == 2'b01);
    assign vote_no  = (prev_code == 2'b00) && (code == 2'b10);

    assign total_next = yes_wide + no_wide + (CNT_W+1)'(vote_yes | vote_no);
    assign close_win  = (total_next == N_LAST) || (timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            result    <= RES_NONE;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            timer     <= '0;
            prev_code <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_COLLECT;
                        yes_cnt   <= '0;
                        no_cnt    <= '0;
                        timer     <= '0;
                        result    <= RES_NONE;
                        prev_code <= code;
                    end
                end
                ST_COLLECT: begin
                    prev_code <= code;
                    timer     <= timer + TMR_W'(1);
                    if (vote_yes) yes_cnt <= yes_cnt + CNT_W'(1);
                    if (vote_no)  no_cnt  <= no_cnt + CNT_W'(1);
                    if (close_win) state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (yes_wide > no_wide)      result <= RES_PASS;
                    else if (no_wide > yes_wide) result <= RES_FAIL;
                    else                         result <= RES_TIE;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jury_vote_tally.sv
// Directed bench for jury_vote_tally: hand-computed tallies, verdicts, timeout and reset cases.
module tb_jury_vote_tally;
    logic       clk = 1'b0;
    logic       rst, start, S1, S0;
    logic       busy, done;
    logic [1:0] result;
    logic [1:0] yes_cnt, no_cnt;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int done_cnt = 0;
    int t0;

    jury_vote_tally #(.N_JURY(3), .CNT_W(2), .TIMEOUT(15), .TMR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .S1(S1), .S0(S0),
        .busy(busy), .done(done), .result(result),
        .yes_cnt(yes_cnt), .no_cnt(no_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic cyc(input logic [1:0] code, input logic st);
        {S1, S0} = code;
        start = st;
        @(posedge clk);
        #1;
        ncyc++;
        if (done) done_cnt++;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            cyc(2'b00, 1'b0);
            n++;
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_out(input string tag, input int b, input int r, input int y, input int n);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_result"}, result, r);
        chk({tag, "_yes"}, yes_cnt, y);
        chk({tag, "_no"}, no_cnt, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; S1 = 1'b0; S0 = 1'b0;
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        rst = 1'b0;
        chk("rst_done", done, 0);
        chk_out("rst", 0, 0, 0, 0);

        // 1: three yes votes close the window early
        done_cnt = 0;
        cyc(2'b00, 1'b1);
        chk("t1_busy_open", busy, 1);
        cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b01, 1'b0); cyc(2'b00, 1'b0);
        cyc(2'b01, 1'b0);
        chk("t1_decide_busy", busy, 1);
        chk("t1_decide_done", done, 0);
        cyc(2'b00, 1'b0);
        chk("t1_done", done, 1);
        chk_out("t1", 0, 1, 3, 0);
        cyc(2'b00, 1'b0);
        chk("t1_done_drop", done, 0);
        chk("t1_result_held", result, 1);
        chk("t1_done_pulses", done_cnt, 1);

        // 2: one yes, two no -> FAIL
        cyc(2'b00, 1'b1);
        cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b10, 1'b0); cyc(2'b00, 1'b0);
        cyc(2'b10, 1'b0);
        wait_done("t2", 4);
        chk_out("t2", 0, 2, 1, 2);

        // 3: held yes counts once, 11 never counts, timeout 16 edges after open
        cyc(2'b00, 1'b1);
        t0 = ncyc;
        for (int i = 0; i < 6; i++) cyc(2'b01, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0);
        chk("t3_mid_yes", yes_cnt, 1);
        wait_done("t3", 20);
        chk("t3_latency", ncyc - t0, 16);
        chk_out("t3", 0, 1, 1, 0);

        // 4: 1/1 then silence -> TIE at timeout
        cyc(2'b00, 1'b1);
        t0 = ncyc;
        cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b10, 1'b0);
        wait_done("t4", 20);
        chk("t4_latency", ncyc - t0, 16);
        chk_out("t4", 0, 3, 1, 1);

        // 5: reset mid-window discards the tally, no done pulse
        done_cnt = 0;
        cyc(2'b00, 1'b1);
        cyc(2'b01, 1'b0);
        chk("t5_pre_yes", yes_cnt, 1);
        rst = 1'b1;
        cyc(2'b00, 1'b0);
        rst = 1'b0;
        chk("t5_rst_done", done, 0);
        chk_out("t5_rst", 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(2'b00, 1'b0);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle_busy", busy, 0);
        cyc(2'b00, 1'b1);
        cyc(2'b10, 1'b0); cyc(2'b00, 1'b0); cyc(2'b10, 1'b0); cyc(2'b00, 1'b0);
        cyc(2'b10, 1'b0);
        wait_done("t5b", 4);
        chk_out("t5b", 0, 2, 0, 3);

        // 6: votes in IDLE ignored
        cyc(2'b01, 1'b0); cyc(2'b00, 1'b0); cyc(2'b10, 1'b0); cyc(2'b00, 1'b0);
        chk_out("t6_idle", 0, 2, 0, 3);
        // open with 01 held, 01->10 without release, start pulsed mid-window
        cyc(2'b01, 1'b1);
        chk_out("t6_open", 1, 0, 0, 0);
        cyc(2'b01, 1'b0);
        cyc(2'b10, 1'b0);
        chk("t6_noedge_yes", yes_cnt, 0);
        chk("t6_noedge_no", no_cnt, 0);
        cyc(2'b00, 1'b0);
        cyc(2'b01, 1'b1);
        chk_out("t6_midstart", 1, 0, 1, 0);
        cyc(2'b00, 1'b1);
        cyc(2'b10, 1'b0); cyc(2'b00, 1'b0); cyc(2'b10, 1'b0);
        cyc(2'b00, 1'b0);
        chk("t6_done", done, 1);
        chk_out("t6", 0, 2, 1, 2);
        // start during the done cycle is accepted and clears the result
        cyc(2'b00, 1'b1);
        chk("t6_restart_done", done, 0);
        chk_out("t6_restart", 1, 0, 0, 0);
        wait_done("t6_empty", 20);
        chk_out("t6_empty", 0, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
